// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM burst controller: FSM states, op codes,
// default timing/geometry values and a counter-width helper.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam int DEF_DW    = 32;
    localparam int DEF_AW    = 17;
    localparam int DEF_BURST = 2;
    localparam int DEF_WAIT  = 5;
    localparam int DEF_BASE  = 1024;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Wait-cycle and beat counters for one SRAM access; flags the last cycle of
// each beat and the last beat of the burst. Counters idle at zero when !run.
module sram_beat_timer
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT,
    parameter int BURST       = DEF_BURST,
    localparam int BCW        = cnt_width(BURST)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic [BCW-1:0] last_beat,
    output logic [BCW-1:0] beat_idx,
    output logic           beat_last,
    output logic           burst_last
);

    localparam int             WCW      = cnt_width(WAIT_CYCLES);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(WAIT_CYCLES - 1);

    logic [WCW-1:0] wait_cnt;

    assign beat_last  = run && (wait_cnt == WAIT_MAX);
    assign burst_last = beat_last && (beat_idx == last_beat);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            wait_cnt <= '0;
            beat_idx <= '0;
        end else if (beat_last) begin
            wait_cnt <= '0;
            beat_idx <= burst_last ? '0 : beat_idx + BCW'(1);
        end else begin
            wait_cnt <= wait_cnt + WCW'(1);
        end
    end

endmodule

// File: rtl/sram_burst_ctrl.sv
// MEM-stage to external SRAM bridge with wait states, aligned read bursts and a
// ready/freeze handshake. Define SRAM_BURST_CTRL_WRBUF_EN for a posted write buffer.
module sram_burst_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DW          = DEF_DW,
    parameter int AW          = DEF_AW,
    parameter int BURST       = DEF_BURST,
    parameter int WAIT_CYCLES = DEF_WAIT,
    parameter int BASE_ADDR   = DEF_BASE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic                wr_en,
    input  logic [31:0]         addr,
    input  logic [DW-1:0]       wdata,
    output logic [DW*BURST-1:0] rdata,
    output logic                ready,
    inout  wire  [DW-1:0]       SRAM_DQ,
    output logic [AW-1:0]       SRAM_ADDR,
    output logic                SRAM_WE_N
);

    localparam int            BCW       = cnt_width(BURST);
    localparam int            BYTE_SH   = $clog2(DW / 8);
    localparam logic [AW-1:0] LINE_MASK = AW'(BURST - 1);

`ifdef SRAM_BURST_CTRL_WRBUF_EN
    localparam bit WRBUF = 1'b1;
`else
    localparam bit WRBUF = 1'b0;
`endif

    state_t         state, state_nxt;
    op_t            op_q;
    logic           posted_q;
    logic [AW-1:0]  word_q;
    logic [DW-1:0]  wdata_q;
    logic           req;
    logic           run;
    logic           write_beat;
    logic [BCW-1:0] last_beat;
    logic [BCW-1:0] beat_idx;
    logic           beat_last;
    logic           burst_last;

    assign req        = rd_en | wr_en;
    assign run        = (state == ST_ACCESS);
    assign write_beat = run && (op_q == OP_WRITE);
    assign last_beat  = (op_q == OP_WRITE) ? '0 : BCW'(BURST - 1);

    sram_beat_timer #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .BURST      (BURST)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .last_beat (last_beat),
        .beat_idx  (beat_idx),
        .beat_last (beat_last),
        .burst_last(burst_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // A posted write is acknowledged in the cycle it is captured.
                ready = ~req | (WRBUF & wr_en);
                if (req) state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (burst_last) state_nxt = posted_q ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                ready     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_READ;
            posted_q <= 1'b0;
            word_q   <= '0;
            wdata_q  <= '0;
            rdata    <= '0;
        end else begin
            if (state == ST_IDLE && req) begin
                op_q     <= wr_en ? OP_WRITE : OP_READ;
                posted_q <= WRBUF & wr_en;
                word_q   <= AW'((addr - 32'(BASE_ADDR)) >> BYTE_SH);
                wdata_q  <= wdata;
            end
            if (run && op_q == OP_READ && beat_last) begin
                for (int k = 0; k < BURST; k++) begin
                    if (beat_idx == BCW'(k)) rdata[k*DW +: DW] <= SRAM_DQ;
                end
            end
        end
    end

    // Reads walk the aligned line; writes always target the latched word.
    assign SRAM_ADDR = (op_q == OP_WRITE) ? word_q
                                          : ((word_q & ~LINE_MASK) | AW'(beat_idx));
    assign SRAM_WE_N = ~write_beat;
    assign SRAM_DQ   = write_beat ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Self-checking bench for sram_burst_ctrl: SRAM model, transaction-level reference
// model with a per-cycle compare process, directed cases and randomized traffic.
`timescale 1ns/1ps
module tb_sram_burst_ctrl;
    import sram_ctrl_pkg::*;

    localparam int DW    = DEF_DW;
    localparam int AW    = DEF_AW;
    localparam int BURST = DEF_BURST;
    localparam int W     = DEF_WAIT;
    localparam int BASE  = DEF_BASE;
    localparam int LW    = DW * BURST;
    localparam int WORDS = 1 << AW;

`ifdef SRAM_BURST_CTRL_WRBUF_EN
    localparam bit WRBUF = 1'b1;
`else
    localparam bit WRBUF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en;
    logic          wr_en;
    logic [31:0]   addr;
    logic [DW-1:0] wdata;
    logic [LW-1:0] rdata;
    logic          ready;
    wire  [DW-1:0] dq;
    logic [AW-1:0] sram_addr;
    logic          sram_we_n;

    sram_burst_ctrl #(
        .DW(DW), .AW(AW), .BURST(BURST), .WAIT_CYCLES(W), .BASE_ADDR(BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .SRAM_DQ  (dq),
        .SRAM_ADDR(sram_addr),
        .SRAM_WE_N(sram_we_n)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_val(input int w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // SRAM model: async read; a write commits on WE_N rising only if the pulse
    // lasted the full required write time.
    logic [DW-1:0] sram [WORDS];
    int            we_cnt = 0;
    logic [AW-1:0] we_addr;
    logic [DW-1:0] we_data;

    initial for (int i = 0; i < WORDS; i++) sram[i] <= init_val(i);

    assign dq = sram_we_n ? sram[sram_addr] : 'z;

    always @(posedge clk) begin
        if (!sram_we_n) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= sram_addr;
            we_data <= dq;
        end else begin
            if (we_cnt == W) sram[we_addr] <= we_data;
            we_cnt <= 0;
        end
    end

    // Reference model: one access at a time, described by its window of SRAM
    // activity and the cycle at which ready must pulse.
    logic [DW-1:0] ref_mem [int];
    int            free_at  = 0;
    int            ready_at = -1;
    int            win_lo   = 1;
    int            win_hi   = 0;
    bit            win_wr   = 1'b0;
    int            win_word = 0;
    int            win_base = 0;
    logic [DW-1:0] win_data = '0;
    logic [LW-1:0] exp_rdata = '0;

    function automatic logic [DW-1:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'(BASE);
        return int'((off >> 2) & 32'(WORDS - 1));
    endfunction

    always @(negedge clk) begin
        bit            in_win;
        bit            exp_rdy;
        logic [AW-1:0] exp_a;
        if (rst) begin
            free_at   = cyc + 1;
            ready_at  = -1;
            win_lo    = 1;
            win_hi    = 0;
            exp_rdata = '0;
        end else begin
            in_win = (cyc >= win_lo) && (cyc <= win_hi);
            if (cyc == ready_at)    exp_rdy = 1'b1;
            else if (cyc >= free_at) exp_rdy = (!rd_en && !wr_en) || (WRBUF && wr_en);
            else                     exp_rdy = 1'b0;
            check("ready", ready, exp_rdy);
            check("we_n", sram_we_n, !(in_win && win_wr));
            if (in_win) begin
                exp_a = win_wr ? AW'(win_word) : AW'(win_base + (cyc - win_lo) / W);
                check("sram_addr", sram_addr, exp_a);
            end
            if (!(in_win && !win_wr)) check("rdata", rdata, exp_rdata);
            if (in_win && win_wr && cyc == win_hi) ref_mem[win_word] = win_data;

            if (cyc >= free_at && (rd_en || wr_en)) begin
                win_lo = cyc + 1;
                if (wr_en) begin
                    win_wr   = 1'b1;
                    win_word = word_of(addr);
                    win_data = wdata;
                    win_hi   = cyc + W;
                    if (WRBUF) begin
                        ready_at = -1;
                        free_at  = cyc + W + 1;
                    end else begin
                        ready_at = cyc + W + 1;
                        free_at  = cyc + W + 2;
                    end
                end else begin
                    win_wr   = 1'b0;
                    win_base = word_of(addr) & ~(BURST - 1);
                    win_hi   = cyc + BURST * W;
                    ready_at = win_hi + 1;
                    free_at  = win_hi + 2;
                    for (int k = 0; k < BURST; k++) exp_rdata[k*DW +: DW] = ref_rd(win_base + k);
                end
            end
        end
    end

    // Drive one request (called at posedge+1), hold it until ready, then drop it.
    task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [DW-1:0] d,
                       output int lat, output int we_lo,
                       output logic [AW-1:0] a0, output logic [AW-1:0] a1);
        int start;
        bit got;
        rd_en = rd; wr_en = wr; addr = a; wdata = d;
        start = cyc; lat = -1; we_lo = 0; a0 = '0; a1 = '0; got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (cyc - start == 1)     a0 = sram_addr;
            if (cyc - start == 1 + W) a1 = sram_addr;
            if (!sram_we_n) we_lo++;
            if (ready) begin
                got = 1'b1;
                lat = cyc - start;
            end
        end
        if (!got) check("txn_timeout_ready", ready, 1'b1);
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int            lat, wlo, r1, r2, op;
        logic [AW-1:0] a0, a1;
        logic [31:0]   ra;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset held two cycles in the middle of a write beat.
        wr_en = 1'b1; addr = 32'd1064; wdata = 32'hCAFE_F00D;
        idle(2);
        rst = 1'b1; wr_en = 1'b0;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("t1_ready_after_rst", ready, 1'b1);
        check("t1_we_n_after_rst", sram_we_n, 1'b1);
        check("t1_rdata_after_rst", rdata, '0);
        idle(W + 2);
        check("t1_sram_untouched", sram[10], init_val(10));

        // Single write to word 1.
        txn(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, lat, wlo, a0, a1);
`ifdef SRAM_BURST_CTRL_WRBUF_EN
        check("t2_posted_latency", lat, 0);
`else
        check("t2_latency", lat, 6);
        check("t2_we_low_cycles", wlo, 5);
        check("t2_sram_addr", a0, 17'd1);
`endif
        idle(W + 2);
        check("t2_sram_word1", sram[1], 32'hDEAD_BEEF);

        // Line read of words 0/1 after writing A and B.
        txn(1'b0, 1'b1, 32'd1024, 32'h1111_AAAA, lat, wlo, a0, a1);
        idle(W + 2);
        txn(1'b0, 1'b1, 32'd1028, 32'h2222_BBBB, lat, wlo, a0, a1);
        idle(W + 2);
        txn(1'b1, 1'b0, 32'd1028, '0, lat, wlo, a0, a1);
        check("t3_latency", lat, 11);
        check("t3_beat0_addr", a0, 17'd0);
        check("t3_beat1_addr", a1, 17'd1);
        check("t3_rdata", rdata, 64'h2222_BBBB_1111_AAAA);
        idle(2);

        // Read and write together: the write wins.
        txn(1'b1, 1'b1, 32'd1032, 32'h0BAD_F00D, lat, wlo, a0, a1);
`ifdef SRAM_BURST_CTRL_WRBUF_EN
        check("t4_posted_latency", lat, 0);
`else
        check("t4_latency", lat, 6);
        check("t4_we_low_cycles", wlo, 5);
`endif
        check("t4_rdata_unchanged", rdata, 64'h2222_BBBB_1111_AAAA);
        idle(W + 2);
        check("t4_sram_word2", sram[2], 32'h0BAD_F00D);

        // Two reads with rd_en held continuously.
        rd_en = 1'b1; addr = 32'd1088; r1 = -1; r2 = -1;
        for (int n = 0; n < 100 && r2 < 0; n++) begin
            @(negedge clk);
            if (ready) begin
                if (r1 < 0) r1 = cyc;
                else        r2 = cyc;
            end
        end
        check("t5_ready_gap", r2 - r1, 12);
        @(posedge clk); #1;
        rd_en = 1'b0;
        idle(2);

`ifdef SRAM_BURST_CTRL_WRBUF_EN
        // Posted write followed at once by a read of the same word.
        txn(1'b0, 1'b1, 32'd1040, 32'h5EED_1234, lat, wlo, a0, a1);
        check("t6_write_latency", lat, 0);
        txn(1'b1, 1'b0, 32'd1040, '0, lat, wlo, a0, a1);
        check("t6_read_latency", lat + 1, 17);
        check("t6_read_data", rdata[31:0], 32'h5EED_1234);
        idle(2);
`endif

        // Randomized traffic, including addresses below the base that wrap.
        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 9));
            if ($urandom_range(0, 9) == 0) ra = 32'(BASE) - 32'($urandom_range(1, 64));
            else                           ra = 32'(BASE) + 32'($urandom_range(0, 255));
            txn(op <= 4, op >= 4, ra, $urandom, lat, wlo, a0, a1);
            idle(int'($urandom_range(0, 3)));
        end

        idle(3 * W);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
